// File: rtl/tiny_soc_mmio_pkg.sv
// tiny_soc_mmio_pkg
// Shared definitions for the tiny SoC MMIO device:
//   - byte offsets of the four 64-bit registers inside the 32-byte window
//   - reg_sel_e, the register select decoded from offset[4:3]
//   - STATUS register field positions
package tiny_soc_mmio_pkg;

  localparam logic [4:0] OFF_STOP    = 5'h00;
  localparam logic [4:0] OFF_CONSOLE = 5'h08;
  localparam logic [4:0] OFF_CYCLE   = 5'h10;
  localparam logic [4:0] OFF_STATUS  = 5'h18;

  typedef enum logic [1:0] {
    SEL_STOP    = 2'd0,
    SEL_CONSOLE = 2'd1,
    SEL_CYCLE   = 2'd2,
    SEL_STATUS  = 2'd3
  } reg_sel_e;

  localparam int STATUS_OVF_BIT = 63;
  localparam int STATUS_CNT_LSB = 0;
  localparam int STATUS_CNT_W   = 16;

endpackage

// File: rtl/ift_taint_fifo.sv
// ift_taint_fifo
// Synchronous FIFO carrying a data word plus a same-width taint word.
// Taint storage exists only when TINY_SOC_MMIO_TAINT_EN is defined;
// otherwise taint_o is tied to 0 and taint_i is ignored.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   push_i / pop_i     enqueue data_i/taint_i, dequeue head
//   data_o / taint_o   head entry (undefined content while empty)
//   full_o / empty_o   occupancy flags
//   count_o            number of stored entries (0..Depth)
// A push while full is only honoured when a pop happens in the same cycle.
module ift_taint_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       data_i,
  input  logic [Width-1:0]       taint_i,
  output logic [Width-1:0]       data_o,
  output logic [Width-1:0]       taint_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PtrW:0]      wptr_q, rptr_q;
  logic [Width-1:0]   data_mem [Depth];
  logic               do_push, do_pop;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == CntW'(Depth));
  assign empty_o = (wptr_q == rptr_q);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = data_mem[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) data_mem[wptr_q[PtrW-1:0]] <= data_i;
  end

`ifdef TINY_SOC_MMIO_TAINT_EN
  logic [Width-1:0] taint_mem [Depth];

  assign taint_o = taint_mem[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) taint_mem[wptr_q[PtrW-1:0]] <= taint_i;
  end
`else
  logic unused_taint;

  assign taint_o      = '0;
  assign unused_taint = ^taint_i;
`endif

endmodule

// File: rtl/tiny_soc_mmio_dev.sv
// tiny_soc_mmio_dev
// Taint-tracking MMIO target with four 64-bit registers in a 32-byte window
// at BaseAddr: STOP (sticky halt + exit code), CONSOLE (byte FIFO drained over
// a valid/ready stream), CYCLE (free-running counter), STATUS (overflow flag
// and FIFO count). Reads return one cycle after the request; rdata holds
// between reads.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   mmio_{req,we,addr,wdata,strb}_i     request port, each with a _t0 taint shadow
//   mmio_rdata_o / _t0                  read data and taint
//   stop_o / stop_o_t0, stop_code_o     halt flag, its taint, exit code
//   console_valid_o / console_ready_i   console stream handshake
//   console_data_o / _t0                console byte and taint
// Build option: define TINY_SOC_MMIO_TAINT_EN for taint storage and
// propagation; without it every _t0 output is 0 and _t0 inputs are ignored.
module tiny_soc_mmio_dev
  import tiny_soc_mmio_pkg::*;
#(
  parameter int                   AddrWidth = 32,
  parameter int                   DataWidth = 64,
  parameter int                   StrbWidth = DataWidth >> 3,
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'h1000_0000,
  parameter int                   FifoDepth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mmio_req_i,
  input  logic                 mmio_req_i_t0,
  input  logic                 mmio_we_i,
  input  logic                 mmio_we_i_t0,
  input  logic [AddrWidth-1:0] mmio_addr_i,
  input  logic [AddrWidth-1:0] mmio_addr_i_t0,
  input  logic [DataWidth-1:0] mmio_wdata_i,
  input  logic [DataWidth-1:0] mmio_wdata_i_t0,
  input  logic [StrbWidth-1:0] mmio_strb_i,
  input  logic [StrbWidth-1:0] mmio_strb_i_t0,
  output logic [DataWidth-1:0] mmio_rdata_o,
  output logic [DataWidth-1:0] mmio_rdata_o_t0,
  output logic                 stop_o,
  output logic                 stop_o_t0,
  output logic [31:0]          stop_code_o,
  output logic                 console_valid_o,
  input  logic                 console_ready_i,
  output logic [7:0]           console_data_o,
  output logic [7:0]           console_data_o_t0
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  logic [AddrWidth-1:0] offset;
  logic                 hit, wr, rd;
  reg_sel_e             sel;
  logic                 stop_wr, con_wr, ovf_evt, ovf_clr;
  logic                 pop, push, full, empty;
  logic [CntW-1:0]      count;
  logic [7:0]           head, head_t, push_t;
  logic [DataWidth-1:0] rd_val, rdata_q, cycle_q;
  logic                 stop_q, ovf_q;
  logic [31:0]          code_q;
  logic                 unused_bits;

  // Addresses below BaseAddr wrap to huge offsets and miss naturally.
  assign offset = mmio_addr_i - BaseAddr;
  assign hit    = (offset[AddrWidth-1:5] == '0);
  assign sel    = reg_sel_e'(offset[4:3]);
  assign wr     = mmio_req_i & mmio_we_i & hit;
  assign rd     = mmio_req_i & ~mmio_we_i;

  assign stop_wr = wr & (sel == SEL_STOP) & mmio_strb_i[0] & ~stop_q;
  assign con_wr  = wr & (sel == SEL_CONSOLE) & mmio_strb_i[0];
  assign ovf_clr = wr & (sel == SEL_STATUS) & mmio_strb_i[0] & mmio_wdata_i[0];
  assign pop     = ~empty & console_ready_i;
  assign push    = con_wr & (~full | pop);
  assign ovf_evt = con_wr & full & ~pop;

  assign unused_bits = ^{mmio_wdata_i[DataWidth-1:32], mmio_strb_i[StrbWidth-1:1]};

  ift_taint_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (mmio_wdata_i[7:0]),
    .taint_i (push_t),
    .data_o  (head),
    .taint_o (head_t),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (sel)
        SEL_STOP:   rd_val = {31'b0, stop_q, code_q};
        SEL_CYCLE:  rd_val = cycle_q;
        SEL_STATUS: begin
          rd_val[STATUS_OVF_BIT] = ovf_q;
          rd_val[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(count);
        end
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      cycle_q <= '0;
      stop_q  <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (rd) rdata_q <= rd_val;
      if (stop_wr) begin
        stop_q <= 1'b1;
        code_q <= mmio_wdata_i[31:0];
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (ovf_evt)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign mmio_rdata_o    = rdata_q;
  assign stop_o          = stop_q;
  assign stop_code_o     = code_q;
  assign console_valid_o = ~empty;
  assign console_data_o  = empty ? 8'h00 : head;

`ifdef TINY_SOC_MMIO_TAINT_EN
  logic                 ctl_t, stop_t_q, ovf_t_q;
  logic [DataWidth-1:0] rd_t, rdata_t_q;
  logic                 unused_taint;

  assign ctl_t  = mmio_req_i_t0 | mmio_we_i_t0 | (|mmio_addr_i_t0);
  assign push_t = mmio_wdata_i_t0[7:0] | {8{mmio_strb_i_t0[0] | ctl_t}};
  assign unused_taint = ^{mmio_wdata_i_t0[DataWidth-1:32], mmio_strb_i_t0[StrbWidth-1:1]};

  // A tainted request makes the whole read result tainted, hit or miss.
  always_comb begin
    rd_t = '0;
    if (ctl_t) begin
      rd_t = '1;
    end else if (hit) begin
      case (sel)
        SEL_STOP:   rd_t = {31'b0, stop_t_q, {32{stop_t_q}}};
        SEL_STATUS: rd_t[STATUS_OVF_BIT] = ovf_t_q;
        default:    rd_t = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_t_q <= '0;
      stop_t_q  <= 1'b0;
      ovf_t_q   <= 1'b0;
    end else begin
      if (rd) rdata_t_q <= rd_t;
      if (stop_wr) stop_t_q <= ctl_t | mmio_strb_i_t0[0] | (|mmio_wdata_i_t0[31:0]);
      if (ovf_evt)      ovf_t_q <= ctl_t;
      else if (ovf_clr) ovf_t_q <= 1'b0;
    end
  end

  assign mmio_rdata_o_t0   = rdata_t_q;
  assign stop_o_t0         = stop_t_q;
  assign console_data_o_t0 = empty ? 8'h00 : head_t;
`else
  logic unused_taint;

  assign push_t            = '0;
  assign mmio_rdata_o_t0   = '0;
  assign stop_o_t0         = 1'b0;
  assign console_data_o_t0 = '0;
  assign unused_taint = ^{mmio_req_i_t0, mmio_we_i_t0, mmio_addr_i_t0,
                          mmio_wdata_i_t0, mmio_strb_i_t0, head_t};
`endif

endmodule

// File: tb/tb_tiny_soc_mmio_dev.sv
// Bench for tiny_soc_mmio_dev: directed MMIO traffic, a queue-based reference
// model updated on every clock edge, a per-cycle compare process, and literal
// expectations at key points of the scenario.
module tb_tiny_soc_mmio_dev;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] A_STOP  = BASE + 32'h00;
  localparam logic [31:0] A_CON   = BASE + 32'h08;
  localparam logic [31:0] A_CYC   = BASE + 32'h10;
  localparam logic [31:0] A_STAT  = BASE + 32'h18;
  localparam int          DEPTH   = 8;
`ifdef TINY_SOC_MMIO_TAINT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_t, we, we_t, ready;
  logic [31:0] addr, addr_t;
  logic [63:0] wdata, wdata_t;
  logic [7:0]  strb, strb_t;

  logic [63:0] rdata, rdata_t;
  logic        stop, stop_t, cvalid;
  logic [31:0] code;
  logic [7:0]  cdata, cdata_t;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tiny_soc_mmio_dev dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .mmio_req_i        (req),
    .mmio_req_i_t0     (req_t),
    .mmio_we_i         (we),
    .mmio_we_i_t0      (we_t),
    .mmio_addr_i       (addr),
    .mmio_addr_i_t0    (addr_t),
    .mmio_wdata_i      (wdata),
    .mmio_wdata_i_t0   (wdata_t),
    .mmio_strb_i       (strb),
    .mmio_strb_i_t0    (strb_t),
    .mmio_rdata_o      (rdata),
    .mmio_rdata_o_t0   (rdata_t),
    .stop_o            (stop),
    .stop_o_t0         (stop_t),
    .stop_code_o       (code),
    .console_valid_o   (cvalid),
    .console_ready_i   (ready),
    .console_data_o    (cdata),
    .console_data_o_t0 (cdata_t)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_rdata, m_rdata_t, m_cycle;
  logic        m_stop, m_stop_t, m_ovf, m_ovf_t;
  logic [31:0] m_code;
  logic [7:0]  m_q[$];
  logic [7:0]  m_qt[$];
  bit          m_hit, m_ctl, m_pop, m_push;
  int          m_reg;
  logic [7:0]  m_pt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdata = '0; m_rdata_t = '0; m_cycle = '0;
      m_stop = 0; m_stop_t = 0; m_ovf = 0; m_ovf_t = 0; m_code = '0;
      m_q.delete(); m_qt.delete();
    end else begin
      m_hit  = (addr >= BASE) && (addr < BASE + 32);
      m_reg  = int'((addr - BASE) / 8);
      m_ctl  = TEN && (req_t || we_t || (addr_t != 0));
      m_pop  = (m_q.size() != 0) && ready;
      m_push = 0;
      m_pt   = TEN ? (wdata_t[7:0] | ((strb_t[0] || m_ctl) ? 8'hFF : 8'h00)) : 8'h00;
      if (req && !we) begin
        m_rdata   = 64'd0;
        m_rdata_t = 64'd0;
        if (m_hit) begin
          case (m_reg)
            0: begin
              m_rdata   = (64'(m_stop) << 32) | 64'(m_code);
              m_rdata_t = m_stop_t ? 64'h0000_0001_FFFF_FFFF : 64'd0;
            end
            2: m_rdata = m_cycle;
            3: begin
              m_rdata   = (64'(m_ovf) << 63) | 64'(m_q.size());
              m_rdata_t = 64'(m_ovf_t) << 63;
            end
            default: ;
          endcase
        end
        if (m_ctl) m_rdata_t = '1;
      end
      if (req && we && m_hit) begin
        case (m_reg)
          0: if (strb[0] && !m_stop) begin
               m_stop   = 1;
               m_code   = wdata[31:0];
               m_stop_t = TEN && (m_ctl || strb_t[0] || (wdata_t[31:0] != 0));
             end
          1: m_push = strb[0];
          3: if (strb[0] && wdata[0]) begin m_ovf = 0; m_ovf_t = 0; end
          default: ;
        endcase
      end
      if (m_pop) begin void'(m_q.pop_front()); void'(m_qt.pop_front()); end
      if (m_push) begin
        if (m_q.size() < DEPTH) begin m_q.push_back(wdata[7:0]); m_qt.push_back(m_pt); end
        else begin m_ovf = 1; m_ovf_t = m_ctl; end
      end
      m_cycle = m_cycle + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("rdata", rdata, m_rdata);
    chk("rdata_t0", rdata_t, m_rdata_t);
    chk("stop", 64'(stop), 64'(m_stop));
    chk("stop_t0", 64'(stop_t), 64'(m_stop_t));
    chk("stop_code", 64'(code), 64'(m_code));
    chk("console_valid", 64'(cvalid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("console_data", 64'(cdata), 64'(m_q[0]));
      chk("console_data_t0", 64'(cdata_t), 64'(m_qt[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    req = 0; we = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    req = 1; we = 1; addr = a; wdata = d; strb = s;
    @(negedge clk);
    req = 0; we = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    req = 1; we = 0; addr = a;
    @(negedge clk);
    req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 0; req_t = 0; we = 0; we_t = 0; addr = '0; addr_t = '0;
    wdata = '0; wdata_t = '0; strb = '0; strb_t = '0; ready = 0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset rdata", rdata, 64'd0);
    chk("reset stop", 64'(stop), 64'd0);
    chk("reset valid", 64'(cvalid), 64'd0);
    rst_n = 1;

    // cycle counter read after 10 cycles out of reset
    idle(10);
    rd(A_CYC);
    chk("cycle@10", rdata, 64'd10);
    chk("cycle@10 taint", rdata_t, 64'd0);

    // two console bytes, stall then drain
    wr(A_CON, 64'h41, 8'h01);
    chk("first byte", 64'(cdata), 64'h41);
    wr(A_CON, 64'h42, 8'h01);
    idle(2);
    chk("stalled byte", 64'(cdata), 64'h41);
    rd(A_STAT);
    chk("status count 2", rdata, 64'd2);
    ready = 1; idle(1); ready = 0;
    chk("second byte", 64'(cdata), 64'h42);
    rd(A_STAT);
    chk("status count 1", rdata, 64'd1);
    ready = 1; idle(1); ready = 0;
    chk("drained", 64'(cvalid), 64'd0);
    rd(A_STAT);
    chk("status count 0", rdata, 64'd0);

    // overflow: 9 pushes into 8 entries, then push-with-pop while full
    for (int i = 0; i < 9; i++) wr(A_CON, 64'(8'h60 + i), 8'h01);
    rd(A_STAT);
    chk("overflow status", rdata, 64'h8000_0000_0000_0008);
    ready = 1;
    wr(A_CON, 64'h70, 8'h01);
    ready = 0;
    rd(A_STAT);
    chk("full push+pop", rdata, 64'h8000_0000_0000_0008);
    wr(A_STAT, 64'h1, 8'h01);
    rd(A_STAT);
    chk("overflow cleared", rdata, 64'd8);
    ready = 1; idle(7); ready = 0;
    chk("last byte", 64'(cdata), 64'h70);
    ready = 1; idle(1); ready = 0;

    // stop register, strobe gating and stickiness
    wr(A_STOP, 64'hDEAD, 8'h02);
    chk("stop strb gated", 64'(stop), 64'd0);
    wr(A_STOP, 64'hDEAD, 8'h01);
    chk("stop set", 64'(stop), 64'd1);
    wr(A_STOP, 64'h1, 8'hFF);
    chk("stop code sticky", 64'(code), 64'hDEAD);
    rd(A_STOP);
    chk("stop readback", rdata, 64'h0000_0001_0000_DEAD);

    // asynchronous reset mid-stream
    wr(A_CON, 64'h33, 8'h01);
    #2 rst_n = 0;
    #1;
    chk("async rst stop", 64'(stop), 64'd0);
    chk("async rst code", 64'(code), 64'd0);
    chk("async rst valid", 64'(cvalid), 64'd0);
    chk("async rst rdata", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1;

    // taint scenario (all _t0 outputs stay 0 without the taint build)
    wdata_t = 64'h01;
    wr(A_CON, 64'h55, 8'h01);
    wdata_t = '0;
    chk("pushed byte", 64'(cdata), 64'h55);
    chk("pushed taint", 64'(cdata_t), TEN ? 64'h01 : 64'h00);
    addr_t = 32'h1;
    rd(A_CYC);
    addr_t = '0;
    chk("tainted read", rdata_t, TEN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
    rd(A_CYC + 32'h3);
    rd(BASE + 32'h20);
    chk("miss read", rdata, 64'd0);
    chk("miss read taint", rdata_t, 64'd0);
    wr(BASE - 32'h8, 64'h77, 8'h01);
    chk("miss write ignored", 64'(cdata), 64'h55);
    strb_t = 8'h01;
    wr(A_STOP, 64'h7, 8'h01);
    strb_t = '0;
    chk("stop taint", 64'(stop_t), TEN ? 64'd1 : 64'd0);
    chk("stop code 7", 64'(code), 64'h7);

    ready = 1; idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tiny_soc_mmio_dev.md
Name: tiny_soc_mmio_dev

Overview:
- Taint-tracking MMIO target that consumes the SoC MMIO request port (req/addr/wdata/strb/we plus `_t0` shadows) and returns `mmio_rdata` with its taint.
- Implements four 64-bit registers: stop/exit code, console TX (buffered in a FIFO and drained over a valid/ready stream), free-running cycle counter, and status.
- Sits directly downstream of the core's MMIO port, beside the instruction/data SRAM; gives the fuzzing bench a halt signal and a console.

Parameters:
- AddrWidth, 32, MMIO address width.
- DataWidth, 64, data width; fixed at 64.
- StrbWidth, DataWidth>>3, byte strobes.
- BaseAddr, 32'h1000_0000, base of the 32-byte register window.
- FifoDepth, 8, console FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mmio_req_i / mmio_req_i_t0  in  1 / 1  request strobe and its taint
- mmio_we_i / mmio_we_i_t0  in  1 / 1  write enable and its taint
- mmio_addr_i / mmio_addr_i_t0  in  AddrWidth / AddrWidth  byte address and its taint
- mmio_wdata_i / mmio_wdata_i_t0  in  DataWidth / DataWidth  write data and its taint
- mmio_strb_i / mmio_strb_i_t0  in  StrbWidth / StrbWidth  byte strobes and their taint
- mmio_rdata_o / mmio_rdata_o_t0  out  DataWidth / DataWidth  read data and its taint
- stop_o / stop_o_t0  out  1 / 1  sticky halt and its taint
- stop_code_o  out  32  exit code
- console_valid_o  out  1  console byte available
- console_ready_i  in  1  consumer accepts byte
- console_data_o / console_data_o_t0  out  8 / 8  console byte and its taint

Behaviour:
- Reset state (async, active-low): all outputs 0; FIFO empty; counter 0; overflow 0.
- Decode:
  - offset = mmio_addr_i − BaseAddr; hit when 0 ≤ offset < 32.
  - Register select = offset[4:3]: 0=STOP, 1=CONSOLE, 2=CYCLE, 3=STATUS.
  - offset[2:0] is ignored.
- Miss: writes are ignored; reads return 0.
- Read latency: exactly 1 cycle.
  - rdata registers the selected value on a cycle with req & ~we.
  - rdata holds its value while no read is issued.
- STOP (W, read returns {31'b0, stop, stop_code}):
  - A write with strb[0] set sets stop_o=1 and stop_code_o=wdata[31:0].
  - Subsequent writes are ignored; stop_o is sticky until reset.
- CONSOLE (W, reads 0):
  - A write with strb[0] set pushes wdata[7:0].
  - Full with no pop in the same cycle: the byte is dropped and the overflow bit is set.
  - Full with a pop in the same cycle: the push succeeds.
- Console stream:
  - console_valid_o = FIFO not empty; console_data_o = head entry.
  - Pop occurs on valid & ready.
  - Data stays stable while valid & ~ready.
- CYCLE (R): 64-bit counter, +1 every cycle, wraps FFFF_FFFF_FFFF_FFFF→0. A read returns the value present in the request cycle.
- STATUS:
  - Read = {overflow at bit 63, count in bits [15:0]}, zero-padded.
  - A write with strb[0] & wdata[0] clears overflow.
  - A clear in the same cycle as an overflow event: the set wins.
- Taint:
  - ctl_t = req_t0 | we_t0 | |addr_t0.
  - Pushed byte taint = wdata_t0[7:0] | {8{strb_t0[0] | ctl_t}}.
  - stop_o_t0 = ctl_t | strb_t0[0] | |wdata_t0[31:0], captured on the setting write.
  - Read taint = all-ones if ctl_t in the request cycle; otherwise the register's stored taint. CYCLE taint is 0.
  - STATUS taint = overflow_t at bit 63, where overflow_t is captured from ctl_t on the overflow event.

Optional Feature:
- TINY_SOC_MMIO_TAINT_EN
  - Defined: full taint storage and propagation as specified above.
  - Undefined: no taint state is instantiated; all `_t0` outputs are tied to 0; `_t0` inputs are ignored.

Decomposition:
- Package tiny_soc_mmio_pkg holds:
  - register offset localparams (OFF_STOP=0x0, OFF_CONSOLE=0x8, OFF_CYCLE=0x10, OFF_STATUS=0x18);
  - a reg_sel_e enum;
  - the STATUS bit positions.
- One sub-module, ift_taint_fifo: a parameterised data+taint FIFO with push/pop/full/empty/count. It stores taint only when TINY_SOC_MMIO_TAINT_EN is defined.

Test Plan:
- Reset, then read CYCLE at cycle 10 → rdata = 10 in the next cycle, taint 0; stop_o=0, console_valid_o=0.
- Write 0x41, 0x42 to 0x1000_0008 with ready=0, then ready=1 → stream emits 0x41 then 0x42, data stable while stalled; STATUS count goes 2→1→0.
- With ready=0, push 9 bytes (depth 8) → 9th byte dropped; STATUS bit63=1, count=8. Then push while full and ready=1 in the same cycle → push accepted. Then a STATUS clear write → bit63=0.
- Write 0xDEAD to STOP, then write 0x1 → stop_o=1, stop_code_o=0xDEAD sticky. Assert rst_ni low mid-stream → all state cleared asynchronously.
- Push 0x55 with wdata_t0=0x01 → console_data_o_t0=0x01. Read CYCLE with addr_t0=1 → rdata_t0=all-ones. Read 0x1000_0020 (miss) → rdata 0.
- Build without TINY_SOC_MMIO_TAINT_EN and repeat the previous scenario with tainted inputs → all `_t0` outputs remain 0.
